// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory arbiter
package mem_arb_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 32;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_TIMEOUT    = 255;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_IF  = 2'd1,
      GRANT_MEM = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - bus acknowledge watchdog, expires on the TIMEOUT-th grant cycle
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // count holds the number of grant cycles already elapsed, so the
   // current cycle is the TIMEOUT-th one when count reaches TIMEOUT-1
   assign expired = enable && (count == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM to Wishbone arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_ack,
   output logic                    if_busy,

   input  logic                    mem_req,
   input  logic                    mem_we,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_sel,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    mem_ack,
   output logic                    mem_busy,

   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,

   output logic                    err
);

   state_t state;
   state_t next_state;

   logic elig_if;
   logic elig_mem;
   logic pick_if;
   logic pick_mem;
   logic grant_if;
   logic grant_mem;
   logic done;
   logic fail;
   logic in_grant;
   logic expired;

   assign if_busy  = if_req  & ~if_ack;
   assign mem_busy = mem_req & ~mem_ack;

   // a port whose ack is showing this cycle has already been served
   assign elig_if  = if_req  & ~if_ack;
   assign elig_mem = mem_req & ~mem_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t last_grant;

   always_comb begin
      pick_mem = elig_mem;
      pick_if  = elig_if & ~elig_mem;
      if (elig_if && elig_mem && (last_grant == OWNER_MEM)) begin
         pick_mem = 1'b0;
         pick_if  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= OWNER_IF;
      end else if (grant_if) begin
         last_grant <= OWNER_IF;
      end else if (grant_mem) begin
         last_grant <= OWNER_MEM;
      end
   end
`else
   assign pick_mem = elig_mem;
   assign pick_if  = elig_if & ~elig_mem;
`endif

   assign in_grant = (state == GRANT_IF) || (state == GRANT_MEM);

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .resetn  (reset),
      .clear   (grant_if | grant_mem),
      .enable  (in_grant),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      grant_if   = 1'b0;
      grant_mem  = 1'b0;
      done       = 1'b0;
      fail       = 1'b0;
      case (state)
         IDLE: begin
            if (pick_mem) begin
               grant_mem  = 1'b1;
               next_state = GRANT_MEM;
            end else if (pick_if) begin
               grant_if   = 1'b1;
               next_state = GRANT_IF;
            end
         end
         GRANT_IF, GRANT_MEM: begin
            // a real acknowledge beats a coincident error or timeout
            if (wb_ack_i) begin
               done       = 1'b1;
               next_state = IDLE;
            end else if (wb_err_i || expired) begin
               done       = 1'b1;
               fail       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_sel_o  <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_ack    <= 1'b0;
         mem_ack   <= 1'b0;
         err       <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         err     <= 1'b0;
         if (grant_mem) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= mem_we;
            wb_adr_o <= mem_addr;
            wb_dat_o <= mem_wdata;
            wb_sel_o <= mem_sel;
         end else if (grant_if) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= if_addr;
            wb_dat_o <= '0;
            wb_sel_o <= '1;
         end
         if (done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err      <= fail;
            if (state == GRANT_IF) begin
               if_ack   <= 1'b1;
               if_rdata <= fail ? '0 : wb_dat_i;
            end else begin
               mem_ack   <= 1'b1;
               mem_rdata <= fail ? '0 : wb_dat_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          if_busy;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic [3:0]    mem_sel = '0;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          mem_busy;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic [DW-1:0] wb_dat_i = '0;
   logic          wb_ack_i = 1'b0;
   logic          wb_err_i = 1'b0;
   logic          err;

   mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .if_busy   (if_busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_sel   (mem_sel),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_busy  (mem_busy),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_sel_o  (wb_sel_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_i  (wb_ack_i),
      .wb_err_i  (wb_err_i),
      .err       (err)
   );

   always #5 clk = ~clk;

   // kind: 0 slave acks, 1 slave errors, 2 slave silent; resp = cycle of response (cyc first high in cycle 1)
   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          kind;
      int          resp;
      logic [31:0] rdat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_end;
   } vec_t;

   localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

   vec_t        vecs [7];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_mem_rdata = '0;
   logic        winner_mem;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      if (v.port) begin
         mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_sel = v.sel;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      chk($sformatf("v%0d_busy_req", idx), 64'(v.port ? mem_busy : if_busy), 64'(1));
      for (int c = 1; c <= v.exp_end; c++) begin
         step();
         wb_ack_i = (v.kind == 0) && (c == v.resp);
         wb_err_i = (v.kind == 1) && (c == v.resp);
         wb_dat_i = ((v.kind != 2) && (c == v.resp)) ? v.rdat : JUNK;
         #1;
         chk($sformatf("v%0d_c%0d_ctl", idx, c), 64'({wb_cyc_o, wb_stb_o, wb_we_o}),
             64'({1'b1, 1'b1, v.port & v.we}));
         chk($sformatf("v%0d_c%0d_adr", idx, c), 64'(wb_adr_o), 64'(v.addr));
         if (v.port)
            chk($sformatf("v%0d_c%0d_sel_dat", idx, c), 64'({wb_sel_o, wb_dat_o}), 64'({v.sel, v.wdata}));
         chk($sformatf("v%0d_c%0d_noack", idx, c), 64'({if_ack, mem_ack, err}), 64'(0));
      end
      step();
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = JUNK;
      #1;
      if (v.port) exp_mem_rdata = v.exp_rdata;
      else exp_if_rdata = v.exp_rdata;
      chk($sformatf("v%0d_ack", idx), 64'({if_ack, mem_ack, err}), 64'({~v.port, v.port, v.exp_err}));
      chk($sformatf("v%0d_cyc_drop", idx), 64'({wb_cyc_o, wb_stb_o}), 64'(0));
      chk($sformatf("v%0d_if_rdata", idx), 64'(if_rdata), 64'(exp_if_rdata));
      chk($sformatf("v%0d_mem_rdata", idx), 64'(mem_rdata), 64'(exp_mem_rdata));
      chk($sformatf("v%0d_busy_ack", idx), 64'(v.port ? mem_busy : if_busy), 64'(0));
      if (v.port) mem_req = 1'b0;
      else if_req = 1'b0;
      step();
      chk($sformatf("v%0d_ack_pulse", idx), 64'({if_ack, mem_ack, err, wb_cyc_o}), 64'(0));
      chk($sformatf("v%0d_rdata_hold", idx), 64'({if_rdata, mem_rdata}), 64'({exp_if_rdata, exp_mem_rdata}));
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 4, 32'h1234_5678, 32'h1234_5678, 1'b0, 4};
      vecs[1] = '{1'b1, 1'b1, 32'h8040_0010, 32'hDEAD_BEEF, 4'hF, 0, 3, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 3};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 2, 0, 32'h0, 32'h0, 1'b1, 8};
      vecs[4] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 1, 2, 32'h7777_7777, 32'h0, 1'b1, 2};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hC, 0, 8, 32'h0F0F_1234, 32'h0F0F_1234, 1'b0, 8};
      vecs[6] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'hF, 0, 7, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 7};

      step();
      step();
      chk("rst_wb_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
      chk("rst_wb_adr", 64'(wb_adr_o), 64'(0));
      chk("rst_wb_dat", 64'(wb_dat_o), 64'(0));
      chk("rst_wb_sel", 64'(wb_sel_o), 64'(0));
      chk("rst_acks", 64'({if_ack, mem_ack, err}), 64'(0));
      chk("rst_rdata", 64'({if_rdata, mem_rdata}), 64'(0));
      reset = 1'b1;
      step();

      // simultaneous requests, both held: MEM, IF, MEM
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8040_0020; mem_wdata = 32'h1111_2222; mem_sel = 4'hF;
      if_req = 1'b1; if_addr = 32'h8000_0100;
      step();
      chk("sim_g1_mem", 64'({wb_cyc_o, wb_we_o, wb_adr_o}), 64'({1'b1, 1'b1, 32'h8040_0020}));
      step(); wb_ack_i = 1'b1; wb_dat_i = 32'hAAAA_0001;
      step(); wb_ack_i = 1'b0; wb_dat_i = JUNK; #1;
      chk("sim_mem_ack", 64'({mem_ack, if_ack, err, wb_cyc_o}), 64'(4'b1000));
      chk("sim_busy", 64'({if_busy, mem_busy}), 64'(2'b10));
      step();
      chk("sim_g2_if", 64'({wb_cyc_o, wb_we_o, wb_adr_o}), 64'({1'b1, 1'b0, 32'h8000_0100}));
      step(); wb_ack_i = 1'b1; wb_dat_i = 32'hBBBB_0002;
      step(); wb_ack_i = 1'b0; wb_dat_i = JUNK; #1;
      chk("sim_if_ack", 64'({if_ack, mem_ack, if_rdata, mem_rdata}), 64'({1'b1, 1'b0, 32'hBBBB_0002, 32'hAAAA_0001}));
      step();
      chk("sim_g3_mem", 64'({wb_cyc_o, wb_we_o, wb_adr_o}), 64'({1'b1, 1'b1, 32'h8040_0020}));
      step(); wb_ack_i = 1'b1; wb_dat_i = 32'hCCCC_0003;
      step(); wb_ack_i = 1'b0; wb_dat_i = JUNK; #1;
      chk("sim_mem_ack2", 64'({mem_ack, mem_rdata}), 64'({1'b1, 32'hCCCC_0003}));
      mem_req = 1'b0; if_req = 1'b0;
      step();
      chk("sim_idle", 64'({wb_cyc_o, if_ack, mem_ack}), 64'(0));
      exp_if_rdata = 32'hBBBB_0002; exp_mem_rdata = 32'hCCCC_0003;

      // fresh tie after MEM was served last: policy decides the winner
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner_mem = 1'b0;
`else
      winner_mem = 1'b1;
`endif
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_sel = 4'hF;
      if_req = 1'b1; if_addr = 32'h8000_0200;
      step();
      chk("tie_winner", 64'(wb_adr_o), 64'(winner_mem ? 32'h0000_0400 : 32'h8000_0200));
      step(); wb_ack_i = 1'b1; wb_dat_i = 32'h1010_1010;
      step(); wb_ack_i = 1'b0; wb_dat_i = JUNK; #1;
      chk("tie_winner_ack", 64'({mem_ack, if_ack}), 64'({winner_mem, ~winner_mem}));
      if (winner_mem) mem_req = 1'b0;
      else if_req = 1'b0;
      step();
      chk("tie_loser", 64'({wb_cyc_o, wb_adr_o}), 64'({1'b1, winner_mem ? 32'h8000_0200 : 32'h0000_0400}));
      wb_ack_i = 1'b1; wb_dat_i = 32'h2020_2020;
      step(); wb_ack_i = 1'b0; wb_dat_i = JUNK; #1;
      chk("tie_loser_ack", 64'({mem_ack, if_ack}), 64'({~winner_mem, winner_mem}));
      mem_req = 1'b0; if_req = 1'b0;
      if (winner_mem) begin exp_mem_rdata = 32'h1010_1010; exp_if_rdata = 32'h2020_2020; end
      else begin exp_if_rdata = 32'h1010_1010; exp_mem_rdata = 32'h2020_2020; end
      step();
      chk("tie_rdata", 64'({if_rdata, mem_rdata}), 64'({exp_if_rdata, exp_mem_rdata}));

      for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

      // reset during GRANT_IF, with a coincident slave ack that must be dropped
      if_req = 1'b1; if_addr = 32'h8000_0300;
      step();
      chk("mr_cyc", 64'(wb_cyc_o), 64'(1));
      step();
      reset = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h3333_3333;
      step();
      chk("mr_cyc_drop", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
      chk("mr_no_ack", 64'({if_ack, mem_ack, err}), 64'(0));
      chk("mr_rdata", 64'({if_rdata, mem_rdata}), 64'(0));
      reset = 1'b1; if_req = 1'b0; wb_ack_i = 1'b0; wb_dat_i = JUNK;
      exp_if_rdata = '0; exp_mem_rdata = '0;
      step();
      chk("mr_after", 64'({if_ack, err, wb_cyc_o}), 64'(0));
      run_txn(vecs[1], 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus data width; byte-select width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for a bus acknowledge.
REQ-004 Port clk, input, 1, single clock; all logic is on posedge clk.
REQ-005 Port reset, input, 1, reset; synchronous and active-low.
REQ-006 Ports if_req (in, 1), if_addr (in, ADDR_WIDTH), if_rdata (out, DATA_WIDTH), if_ack (out, 1), if_busy (out, 1): instruction-fetch read port.
REQ-007 Ports mem_req (in, 1), mem_we (in, 1), mem_addr (in, ADDR_WIDTH), mem_wdata (in, DATA_WIDTH), mem_sel (in, DATA_WIDTH/8), mem_rdata (out, DATA_WIDTH), mem_ack (out, 1), mem_busy (out, 1): data-memory port.
REQ-008 Ports wb_cyc_o, wb_stb_o, wb_we_o (out, 1), wb_adr_o (out, ADDR_WIDTH), wb_dat_o (out, DATA_WIDTH), wb_sel_o (out, DATA_WIDTH/8), wb_dat_i (in, DATA_WIDTH), wb_ack_i, wb_err_i (in, 1): shared Wishbone master.
REQ-009 Port err, output, 1, pulses with the requester ack when a transaction ended by wb_err_i or timeout.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT_IF and GRANT_MEM.
REQ-011 In IDLE with an eligible request, the arbiter SHALL latch the winner's address, wdata, sel and we (we=0 for IF), then enter GRANT_x with wb_cyc_o=wb_stb_o=1 on the next cycle.
REQ-012 Latched bus outputs SHALL stay stable for the whole of GRANT_x.
REQ-013 In GRANT_x on wb_ack_i=1: latch wb_dat_i into x_rdata, drop wb_cyc_o/wb_stb_o, return to IDLE, and pulse x_ack for exactly one cycle on the following cycle.
REQ-014 Latency SHALL be: req at cycle 0 -> cyc at cycle 1 -> ack_i at cycle k -> x_ack at cycle k+1.
REQ-015 x_rdata SHALL hold its value until the next completed transaction on that port.
REQ-016 x_busy SHALL equal x_req AND NOT x_ack (combinational); it feeds the pipeline stall controller.
REQ-017 A requester SHALL hold req and payload until its ack; a request is not re-granted in the cycle its own ack is high.
REQ-018 If IF and MEM requests arrive in the same IDLE cycle, MEM wins, except as modified by REQ-024.
REQ-019 A watchdog SHALL count cycles in GRANT_x, cleared on grant; reaching TIMEOUT without ack_i ends the transaction as in REQ-013 with rdata=0 and err=1.
REQ-020 wb_err_i=1 SHALL end the transaction as in REQ-013 with rdata=0 and err=1.
REQ-021 If wb_ack_i and the timeout occur in the same cycle, wb_ack_i wins and err=0.

Reset
REQ-022 While reset=0 at posedge clk: state=IDLE, watchdog=0, all wb_* outputs=0, if_ack=mem_ack=err=0, if_rdata=mem_rdata=0.
REQ-023 Reset asserted mid-transaction SHALL drop wb_cyc_o/wb_stb_o at that edge and SHALL NOT produce an ack pulse.

Configuration
REQ-024 With macro MEM_ARB_ROUND_ROBIN_EN defined, a last_grant flop (reset value IF) SHALL resolve simultaneous requests to the port not served last; without the macro, arbitration SHALL be fixed MEM priority and no last_grant flop exists.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the state enum (IDLE, GRANT_IF, GRANT_MEM), the grant-owner enum (OWNER_IF, OWNER_MEM) and the default width constants.
REQ-026 The watchdog SHALL be the sub-module mem_arb_watchdog (inputs clear/enable, output expired, parameter TIMEOUT).

Verification
REQ-027 IF read 0x8000_0000, slave acks 3 cycles after cyc -> if_rdata=slave data, if_ack one cycle, if_busy 1 until ack.
REQ-028 MEM write 0x8040_0010, wdata 0xDEADBEEF, sel 0xF -> wb_we_o=1, wb_dat_o/wb_sel_o stable until ack, mem_ack pulse.
REQ-029 IF and MEM requests in the same cycle, both held -> fixed mode: MEM then IF; with the macro: MEM, IF, MEM alternating across repeats.
REQ-030 Slave never acks, TIMEOUT=8 -> cyc drops after 8 cycles, mem_ack=1, err=1, mem_rdata=0.
REQ-031 reset=0 during GRANT_IF -> cyc/stb=0 at the next edge, no if_ack, FSM in IDLE.
REQ-032 wb_ack_i coincident with the timeout cycle -> err=0, rdata=wb_dat_i.
